// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the MEM-stage LSU and memory.
// master = LSU side, slave = memory side.
interface mem_stage_lsu_if #(
  parameter int Width = 32
);
  logic             dmem_req_o;
  logic             dmem_we_o;
  logic [Width-1:0] dmem_addr_o;
  logic [3:0]       dmem_be_o;
  logic [Width-1:0] dmem_wdata_o;
  logic             dmem_gnt_i;
  logic             dmem_rvalid_i;
  logic [Width-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_be_o,
    output dmem_wdata_o,
    input  dmem_gnt_i,
    input  dmem_rvalid_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_be_o,
    input  dmem_wdata_o,
    output dmem_gnt_i,
    output dmem_rvalid_i,
    output dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store into a req/gnt/rvalid
// transaction, stalls the pipe until done, and lane-shifts load data.
module mem_stage_lsu #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRen_MEM,
  input  logic             MemWen_MEM,
  input  logic [2:0]       funct3_MEM,
  input  logic [Width-1:0] alu_MEM,
  input  logic [Width-1:0] dataW_MEM,
  input  logic             hold_i,
  mem_stage_lsu_if.master  dmem,
  output logic [Width-1:0] dataR_o,
  output logic             stall_o,
  output logic             misaligned_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_access;
  logic w_is_b;
  logic w_is_h;
  logic w_mis;
  logic w_go;

  assign w_access = MemRen_MEM | MemWen_MEM;
  assign w_is_b   = (funct3_MEM[1:0] == 2'b00);
  assign w_is_h   = (funct3_MEM[1:0] == 2'b01);
  assign w_mis    = (w_is_h & alu_MEM[0]) |
                    (~w_is_b & ~w_is_h & (alu_MEM[1:0] != 2'b00));
  assign w_go     = w_access & ~w_mis;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Only a response inside WAIT_RSP is captured; late ones are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      dataR_o <= '0;
    else if (r_state == WAIT_RSP && dmem.dmem_rvalid_i)
      dataR_o <= dmem.dmem_rdata_i >> {alu_MEM[1:0], 3'b000};
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_go && dmem.dmem_gnt_i)
          w_next = MemRen_MEM ? WAIT_RSP : DONE;
      end
      WAIT_RSP: begin
        if (dmem.dmem_rvalid_i) w_next = DONE;
      end
      DONE: begin
        if (!hold_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    dmem.dmem_req_o   = 1'b0;
    stall_o           = 1'b0;
    misaligned_o      = 1'b0;
    dmem.dmem_we_o    = MemWen_MEM;
    dmem.dmem_addr_o  = {alu_MEM[Width-1:2], 2'b00};
    dmem.dmem_be_o    = 4'b0000;
    dmem.dmem_wdata_o = dataW_MEM;
    unique case (r_state)
      IDLE: begin
        dmem.dmem_req_o = w_go;
        stall_o         = w_go;
        misaligned_o    = w_access & w_mis;
      end
      WAIT_RSP: stall_o = 1'b1;
      DONE:     stall_o = 1'b0;
      default:  stall_o = 1'b0;
    endcase
    if (MemWen_MEM) begin
      unique case (1'b1)
        w_is_b: begin
          dmem.dmem_be_o    = 4'b0001 << alu_MEM[1:0];
          dmem.dmem_wdata_o = {4{dataW_MEM[7:0]}};
        end
        w_is_h: begin
          dmem.dmem_be_o    = 4'b0011 << alu_MEM[1:0];
          dmem.dmem_wdata_o = {2{dataW_MEM[15:0]}};
        end
        default: dmem.dmem_be_o = 4'b1111;
      endcase
    end else if (MemRen_MEM) begin
      dmem.dmem_be_o = 4'b1111;
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the 5-stage RV32I pipeline. Sits between EX/MEM register outputs and the MEM/WB register, converts load/store requests into a req/gnt/rvalid data-memory transaction, generates byte enables and store-data replication, and stalls the pipeline until the access completes. `dataR_o` is the raw loaded word right-shifted to the addressed byte lane and feeds the MEM/WB register's `dataR` input. Sign/zero extension is done in WB.

## Interface
- `Width`, 32: data/address width (only 32 supported)
- `clk_i` in 1: clock; one clock domain, all state on rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `MemRen_MEM` in 1: load in MEM stage
- `MemWen_MEM` in 1: store in MEM stage (never together with `MemRen_MEM`)
- `funct3_MEM` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W
- `alu_MEM` in Width: effective byte address
- `dataW_MEM` in Width: store data (rs2)
- `hold_i` in 1: downstream/hazard hold; pipeline not advancing this cycle
- `dmem_req_o` out 1: memory request
- `dmem_we_o` out 1: write request
- `dmem_addr_o` out Width: word-aligned address `{alu_MEM[31:2],2'b00}`
- `dmem_be_o` out 4: byte enables
- `dmem_wdata_o` out Width: lane-replicated store data
- `dmem_gnt_i` in 1: request accepted this cycle
- `dmem_rvalid_i` in 1: read data valid
- `dmem_rdata_i` in Width: read data
- `dataR_o` out Width: captured load word, shifted right by `8*alu_MEM[1:0]`
- `stall_o` out 1: freeze IF..MEM and the EX/MEM register
- `misaligned_o` out 1: current access misaligned, suppressed

## Operation
- Access present = `MemRen_MEM | MemWen_MEM`. Misaligned = H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`.
- FSM states: IDLE, WAIT_RSP, DONE.
- IDLE, aligned access: `dmem_req_o=1` and `stall_o=1`, both combinational. Hold until `dmem_gnt_i`. On grant, a load goes to WAIT_RSP and a store goes to DONE.
- IDLE, misaligned access: no request, `stall_o=0`, `misaligned_o=1`, stay IDLE. `dataR_o` is unchanged.
- IDLE, no access: all request outputs 0, `stall_o=0`.
- WAIT_RSP: `dmem_req_o=0`, `stall_o=1`. On `dmem_rvalid_i`, register `dmem_rdata_i >> (8*addr[1:0])` into `dataR_o` and go to DONE.
- DONE: `stall_o=0` and `dmem_req_o=0`. If `hold_i` is set, stay in DONE; otherwise go to IDLE next cycle. This prevents re-issuing the same instruction while it is held.
- Store byte enables:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{dataW[7:0]}}`
  - SH: `be = 4'b0011 << addr[1:0]`, `wdata = {2{dataW[15:0]}}`
  - SW: `be = 4'b1111`, `wdata = dataW`
- Loads: `dmem_we_o=0` and `be=4'b1111`.
- `dmem_rvalid_i` outside WAIT_RSP is ignored. `dmem_gnt_i` without `dmem_req_o` is ignored.
- Address, write-enable, byte-enable and write-data outputs are combinational from MEM-stage inputs. They are stable while `req` is high because `stall_o` freezes EX/MEM.

## Timing
- Reset values: state IDLE, `dataR_o=0`. `dmem_req_o`, `stall_o` and `misaligned_o` are 0 whenever MEM inputs are 0.
- Reset asserted mid-transaction (WAIT_RSP or DONE): go to IDLE on that edge and drop the request. A late `rvalid` is discarded.
- Load with grant in cycle 0 and `rvalid` in cycle 1: `stall_o` is high in cycles 0–1. DONE is in cycle 2, and MEM/WB samples `dataR_o` at the end of cycle 2.
- Store with grant in cycle 0: `stall_o` is high in cycle 0 and the pipeline advances at the end of cycle 1 (DONE).
- Each cycle of grant delay or response delay adds one stall cycle.
- `rvalid` in the cycle directly after the grant is legal and is the minimum latency.
- Back-to-back accesses: the next instruction's request issues in the first IDLE cycle after DONE.

## Test plan
- LW at 0x100, gnt immediate, `rvalid` next cycle with rdata 0xDEADBEEF:
  - `stall_o` reads 1,1,0 over three cycles
  - `dataR_o=0xDEADBEEF` in DONE
- LBU at 0x103, rdata 0x80AABBCC: `dataR_o=0x00000080`.
- LH at 0x102, rdata 0x1234ABCD: `dataR_o=0x00001234`.
- SB at 0x201, data 0x000000A5:
  - `be=0010`, `wdata=0xA5A5A5A5`, `we=1`, `addr=0x200`
  - gnt delayed 3 cycles: `req` and `stall_o` held for 4 cycles, then DONE
- SH at 0x202: `be=1100`.
- LW at 0x102: `misaligned_o=1`, `req=0`, `stall_o=0`, `dataR_o` unchanged.
- LH at 0x101: `misaligned_o=1`.
- DONE with `hold_i=1` for 2 cycles: no second request. A spurious `rvalid` in IDLE leaves `dataR_o` unchanged.
- `rst_i` asserted in WAIT_RSP, then `rvalid` arrives: state IDLE, `dataR_o=0`, `stall_o=0`.
